// File: rtl/dutycycle_ctrl_if.sv
// Handshake/bus bundle between dutycycle_ctrl and its command, sample and result sides.
interface dutycycle_ctrl_if #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned NP_LOG2 = 3
);
    localparam int unsigned SUM_W = CNT_W + NP_LOG2;

    logic             start;
    logic             abort;
    logic             sample_stb;
    logic [CNT_W-1:0] pos_cnt;
    logic [CNT_W-1:0] neg_cnt;
    logic             meas_en;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [SUM_W-1:0] pos_res;
    logic [SUM_W-1:0] neg_res;
    logic             timeout;

    modport master (
        output start, abort, sample_stb, pos_cnt, neg_cnt, res_ready,
        input  meas_en, busy, res_valid, pos_res, neg_res, timeout
    );

    modport slave (
        input  start, abort, sample_stb, pos_cnt, neg_cnt, res_ready,
        output meas_en, busy, res_valid, pos_res, neg_res, timeout
    );
endinterface

// File: rtl/dutycycle_ctrl.sv
// Duty-cycle measurement sequencer: discard partial period, sum 2^NP_LOG2 periods, hand off result.
// Optional DUTYCYCLE_CTRL_AVG_EN: present pos/neg results as averages (sum >> NP_LOG2).
module dutycycle_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned NP_LOG2     = 3,
    parameter int unsigned TO_W        = 32,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input logic               clk,
    input logic               rst,
    dutycycle_ctrl_if.slave   bus
);
    localparam int unsigned SUM_W = CNT_W + NP_LOG2;
    localparam int unsigned PC_W  = NP_LOG2 + 1;
    localparam logic [PC_W-1:0] N_PER   = PC_W'(1) << NP_LOG2;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [SUM_W-1:0]  pos_sum, pos_sum_nxt;
    logic [SUM_W-1:0]  neg_sum, neg_sum_nxt;
    logic [PC_W-1:0]   per_cnt, per_cnt_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic              timeout_q, timeout_nxt;
    logic              to_expire;
    logic              load_res;
    logic [SUM_W-1:0]  pos_res_q, pos_res_nxt;
    logic [SUM_W-1:0]  neg_res_q, neg_res_nxt;
    logic              meas_en_q, busy_q, res_valid_q;

    // Next-state, accumulation and counter logic; abort overrides everything at the end.
    always_comb begin
        state_nxt   = state;
        pos_sum_nxt = pos_sum;
        neg_sum_nxt = neg_sum;
        per_cnt_nxt = per_cnt;
        to_cnt_nxt  = to_cnt;
        timeout_nxt = timeout_q;
        load_res    = 1'b0;
        to_expire   = (to_cnt == TO_LAST) && !bus.sample_stb;

        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt   = ST_ARM;
                    pos_sum_nxt = '0;
                    neg_sum_nxt = '0;
                    per_cnt_nxt = '0;
                    to_cnt_nxt  = '0;
                    timeout_nxt = 1'b0;
                end
            end
            ST_ARM: begin
                if (bus.sample_stb) begin
                    state_nxt  = ST_ACC;
                    to_cnt_nxt = '0;
                end else if (to_expire) begin
                    state_nxt   = ST_IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            ST_ACC: begin
                if (bus.sample_stb) begin
                    pos_sum_nxt = pos_sum + SUM_W'(bus.pos_cnt);
                    neg_sum_nxt = neg_sum + SUM_W'(bus.neg_cnt);
                    per_cnt_nxt = per_cnt + PC_W'(1);
                    to_cnt_nxt  = '0;
                    if (per_cnt_nxt == N_PER) begin
                        state_nxt = ST_DONE;
                        load_res  = 1'b1;
                    end
                end else if (to_expire) begin
                    state_nxt   = ST_IDLE;
                    timeout_nxt = 1'b1;
                    pos_sum_nxt = '0;
                    neg_sum_nxt = '0;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (bus.abort) begin
            state_nxt   = ST_IDLE;
            load_res    = 1'b0;
            timeout_nxt = timeout_q;
        end
    end

    // Result path: optional averaging shift ahead of the output register.
    always_comb begin
        pos_res_nxt = pos_res_q;
        neg_res_nxt = neg_res_q;
        if (load_res) begin
`ifdef DUTYCYCLE_CTRL_AVG_EN
            pos_res_nxt = pos_sum_nxt >> NP_LOG2;
            neg_res_nxt = neg_sum_nxt >> NP_LOG2;
`else
            pos_res_nxt = pos_sum_nxt;
            neg_res_nxt = neg_sum_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pos_sum     <= '0;
            neg_sum     <= '0;
            per_cnt     <= '0;
            to_cnt      <= '0;
            timeout_q   <= 1'b0;
            pos_res_q   <= '0;
            neg_res_q   <= '0;
            meas_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            pos_sum     <= pos_sum_nxt;
            neg_sum     <= neg_sum_nxt;
            per_cnt     <= per_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            timeout_q   <= timeout_nxt;
            pos_res_q   <= pos_res_nxt;
            neg_res_q   <= neg_res_nxt;
            meas_en_q   <= (state_nxt == ST_ARM) || (state_nxt == ST_ACC);
            busy_q      <= (state_nxt != ST_IDLE);
            res_valid_q <= (state_nxt == ST_DONE);
        end
    end

    assign bus.meas_en   = meas_en_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.timeout   = timeout_q;
    assign bus.pos_res   = pos_res_q;
    assign bus.neg_res   = neg_res_q;
endmodule

// File: doc/dutycycle_ctrl.md
# dutycycle_ctrl

Measurement sequencer for the duty-cycle counter core. On a start command it enables the core and discards the first, partial period. It then accumulates the high and low counts of 2^NP_LOG2 complete periods and presents the result on a valid/ready handshake. A cycle-count timeout flags a missing or stuck input waveform.

## Interface
Parameters:
- CNT_W, 32: width of the core's per-period high/low counts.
- NP_LOG2, 3: log2 of the number of periods accumulated (N = 2^NP_LOG2, range 0..8).
- TO_W, 32: width of the timeout counter.
- TIMEOUT_CYC, 50_000_000: clk cycles allowed between consecutive sample strobes.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse that begins a measurement; honoured only in IDLE.
- abort, input, 1: returns the block to IDLE; takes priority over every other input except rst.
- sample_stb, input, 1: one-cycle strobe from the core marking a completed period.
- pos_cnt, input, CNT_W: high-level count for the period; valid only while sample_stb=1.
- neg_cnt, input, CNT_W: low-level count for the period; valid only while sample_stb=1.
- meas_en, output, 1: core enable; high in ARM and ACC.
- busy, output, 1: high in any state other than IDLE.
- res_valid, output, 1: result available; high in DONE.
- res_ready, input, 1: consumer accepts the result when res_valid=1 and res_ready=1.
- pos_res, output, CNT_W+NP_LOG2: accumulated (or averaged) high count.
- neg_res, output, CNT_W+NP_LOG2: accumulated (or averaged) low count.
- timeout, output, 1: sticky error flag; cleared by rst or by the next accepted start.

## Operation
State machine:
- IDLE: start → ARM. On entry, clear the sums, the period counter and the timeout counter. timeout is cleared on that same accepted start.
- ARM: the first sample_stb is discarded (partial period) → ACC. Timeout expiry → IDLE with timeout=1.
- ACC: each sample_stb adds pos_cnt to pos_sum and neg_cnt to neg_sum, then increments the period counter. The N-th strobe → DONE. Timeout expiry → IDLE with timeout=1; sums are discarded and res_valid is never raised.
- DONE: pos_res and neg_res are held stable. Handshake (res_valid & res_ready) → IDLE. sample_stb is ignored.

Arithmetic and counters:
- The sums are CNT_W+NP_LOG2 bits wide and cannot overflow.
- The period counter is NP_LOG2+1 bits wide.
- The timeout counter increments every cycle in ARM and ACC and clears on each sample_stb. It expires when it reaches TIMEOUT_CYC-1 with no strobe in that cycle.

Simultaneous events:
- A strobe and timeout expiry in the same cycle: the strobe wins.
- abort in the same cycle as the N-th strobe: abort wins and there is no DONE.
- start while busy is ignored, including in DONE before the handshake.
- NP_LOG2=0: one sample after the discard goes straight to DONE.

Reset:
- rst mid-operation returns to IDLE on the next edge. Sums are cleared and no result is emitted.

## Timing
- Every output is registered.
- Reset values: meas_en=0, busy=0, res_valid=0, timeout=0, pos_res=0, neg_res=0.
- start at edge k: busy=1 and meas_en=1 from edge k+1.
- The N-th accepted strobe at edge k: res_valid=1 at edge k+1, with pos_res and neg_res already valid at that edge.
- Handshake at edge k: res_valid=0, busy=0 at edge k+1. A new start is honoured from edge k+1.
- Timeout expiry at edge k: timeout=1, busy=0, meas_en=0 at edge k+1.
- Back-to-back measurements: one IDLE cycle minimum between handshake and the next start.

## Configuration
Macro: DUTYCYCLE_CTRL_AVG_EN.
- Defined: pos_res = pos_sum >> NP_LOG2 and neg_res = neg_sum >> NP_LOG2. The shift truncates and the upper NP_LOG2 bits read 0. The shift is combinational ahead of the output register and adds no latency.
- Undefined: pos_res and neg_res carry the raw sums.

## Test plan
- Basic sum (NP_LOG2=2, AVG undefined): start, then 5 strobes with pos=30, neg=70 (the first is discarded) → exactly 1 cycle after the 5th strobe, res_valid=1 with pos_res=120, neg_res=280.
- Average (AVG defined, NP_LOG2=2): strobes of pos 10/11/12/13 after the discard → pos_res=11 (46>>2). Strobes of neg 0/0/0/3 → neg_res=0.
- Timeout (TIMEOUT_CYC=16): start, then no strobe → timeout=1, busy=0 at edge 17 after start. The next start clears timeout.
- Back-pressure: hold res_ready=0 for 20 cycles in DONE while driving strobes and start → results stay stable with no re-entry. res_ready=1 → IDLE the next cycle.
- abort coincident with the N-th strobe → IDLE, res_valid never asserts.
- rst asserted mid-ACC, then a full run → all outputs return to 0. The following measurement is unaffected by the earlier partial sums.
